top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10; clock cycles per timing tick.
REQ-002 SHALL have parameter ESCAPE_TICKS, default 40; ticks from the last beat before pacing.
REQ-003 SHALL have parameter REFRACT_TICKS, default 8; ticks after any beat during which sensing is ignored.
REQ-004 SHALL have parameter HYST_TICKS, default 50; escape limit after a sensed beat when hysteresis is compiled in.
REQ-005 SHALL have parameter PULSE_CYCLES, default 4; LED pulse width in clocks.
REQ-006 SHALL have parameter LFSR_SEED, default 8'hA5, nonzero; heart-model seed.
REQ-007 SHALL have port CLK, input, 1 bit; the single clock, all state on its rising edge.
REQ-008 SHALL have port RSTn, input, 1 bit; reset, asynchronous and active-high (RSTn=1 resets).
REQ-009 SHALL have port LED_HEART, output, 1 bit; pulse on each intrinsic heartbeat.
REQ-010 SHALL have port LED_PACE, output, 1 bit; pulse on each pacing event.

Function
REQ-011 SHALL generate a one-clock tick strobe when a divider counter (0..TICK_DIV-1) equals TICK_DIV-1; the first tick is the TICK_DIV-th clock after reset release.
REQ-012 SHALL model an intrinsic heart: an 8-bit LFSR (shift left, feedback bit7^bit5^bit4^bit3) and a beat timer loaded with 20+lfsr[5:0] ticks (range 20..83).
REQ-013 SHALL fire an intrinsic beat on the tick where the beat timer expires, then step the LFSR and reload the timer from the new value.
REQ-014 SHALL, on each pacing event, step the LFSR and reload the beat timer (the heart is captured).
REQ-015 SHALL implement a pacing FSM with states REFRACT, ALERT and PACE.
REQ-016 REFRACT: count REFRACT_TICKS ticks and ignore intrinsic beats, then go to ALERT.
REQ-017 ALERT: a sensed intrinsic beat goes to REFRACT and reloads the escape limit.
REQ-018 An escape counter SHALL start at 0 on entry to REFRACT, increment per tick across REFRACT and ALERT, and enter PACE on the tick it reaches the current escape limit.
REQ-019 PACE: drive LED_PACE high for exactly PULSE_CYCLES clocks starting the clock after escape expiry, then go to REFRACT.
REQ-020 LED_HEART SHALL be high for PULSE_CYCLES clocks starting the clock after each intrinsic beat, whether or not it is sensed; a new beat restarts the pulse.
REQ-021 Intrinsic beat and escape expiry on the same tick: the beat wins and no pace occurs.
REQ-022 LED_HEART and LED_PACE SHALL be driven directly from registers.

Reset
REQ-023 While RSTn=1: LED_HEART=0, LED_PACE=0, state REFRACT, escape and divider counters 0, LFSR=LFSR_SEED, beat timer=20+LFSR_SEED[5:0], escape limit=ESCAPE_TICKS.
REQ-024 Reset asserted mid-pulse or mid-state SHALL clear the outputs immediately, without waiting for a clock.

Configuration
REQ-025 Macro PACE_HYST_EN: if defined, the escape limit after a sensed beat is HYST_TICKS and after a pace is ESCAPE_TICKS.
REQ-026 If PACE_HYST_EN is undefined, the escape limit is always ESCAPE_TICKS and no hysteresis logic is present.

Verification
REQ-027 Defaults, reset released: first intrinsic due at tick 57 > 40, so LED_PACE high clocks 401-404 and LED_HEART stays low.
REQ-028 After that pace, LFSR=8'h4A, beat timer=30; LED_HEART pulses 4 clocks after tick 70 and there is no pace at tick 80.
REQ-029 Assert RSTn=1 during a LED_PACE pulse: both LEDs go to 0 asynchronously; after release, the sequence repeats from REQ-027.
REQ-030 ESCAPE_TICKS=20 (equal to the minimum intrinsic interval): on a coinciding tick only LED_HEART pulses.
REQ-031 PACE_HYST_EN defined, beat sensed at tick T with no further intrinsic beat: pace on tick T+50, not T+40.
REQ-032 Run 20000 ns at a 10 ns clock: LED_PACE and LED_HEART pulses are each exactly 4 clocks wide, and consecutive events are never closer than 8 ticks.

Source files
------------

// File: rtl/top.sv
// Pacemaker core: tick divider, LFSR-driven intrinsic heart model and a REFRACT/ALERT/PACE escape FSM.
// Defining PACE_HYST_EN compiles in hysteresis (a longer escape limit after a sensed beat).
module top #(
    parameter int         TICK_DIV      = 10,
    parameter int         ESCAPE_TICKS  = 40,
    parameter int         REFRACT_TICKS = 8,
    parameter int         HYST_TICKS    = 50,
    parameter int         PULSE_CYCLES  = 4,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic CLK,
    input  logic RSTn,
    output logic LED_HEART,
    output logic LED_PACE
);
    localparam int ESC_MAX0 = (HYST_TICKS > ESCAPE_TICKS) ? HYST_TICKS : ESCAPE_TICKS;
    localparam int ESC_MAX  = (REFRACT_TICKS > ESC_MAX0) ? REFRACT_TICKS : ESC_MAX0;
    localparam int ESC_W    = $clog2(ESC_MAX + 1);
    localparam int DIV_W    = $clog2(TICK_DIV + 1);
    localparam int PUL_W    = $clog2(PULSE_CYCLES + 1);

    localparam logic [ESC_W-1:0] ESC_LIM  = ESC_W'(ESCAPE_TICKS);
    localparam logic [ESC_W-1:0] REF_LIM  = ESC_W'(REFRACT_TICKS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [PUL_W-1:0] PUL_LOAD = PUL_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {REFRACT, ALERT, PACE} state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [7:0]       lfsr;
    logic [7:0]       lfsr_step;
    logic [6:0]       beat_tmr;
    logic             beat;
    logic [PUL_W-1:0] heart_cnt;
    state_t           state, state_d;
    logic [ESC_W-1:0] esc_cnt, esc_d;
    logic [ESC_W-1:0] esc_lim;
    logic [PUL_W-1:0] pace_cnt, pace_cnt_d;
    logic             pace_d;
    logic             esc_hit, sensed, pace_evt;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge CLK or posedge RSTn) begin
        if (RSTn)      div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

    // Intrinsic heart: the timer counts ticks down to 1, fires, then reloads from the stepped LFSR.
    assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign beat      = tick && (beat_tmr == 7'd1);

    always_ff @(posedge CLK or posedge RSTn) begin
        if (RSTn) begin
            lfsr     <= LFSR_SEED;
            beat_tmr <= 7'd20 + {1'b0, LFSR_SEED[5:0]};
        end else if (beat || pace_evt) begin
            lfsr     <= lfsr_step;
            beat_tmr <= 7'd20 + {1'b0, lfsr_step[5:0]};
        end else if (tick) begin
            beat_tmr <= beat_tmr - 7'd1;
        end
    end

    always_ff @(posedge CLK or posedge RSTn) begin
        if (RSTn) begin
            LED_HEART <= 1'b0;
            heart_cnt <= '0;
        end else if (beat) begin
            LED_HEART <= 1'b1;
            heart_cnt <= PUL_LOAD;
        end else if (heart_cnt != '0) begin
            heart_cnt <= heart_cnt - PUL_W'(1);
        end else begin
            LED_HEART <= 1'b0;
        end
    end

    // A beat that lands on the escape-expiry tick is treated as sensed, so it suppresses the pace.
    assign esc_hit  = tick && (state != PACE) && ((esc_cnt + ESC_W'(1)) == esc_lim);
    assign sensed   = beat && ((state == ALERT) || esc_hit);
    assign pace_evt = esc_hit && !beat;

`ifdef PACE_HYST_EN
    always_ff @(posedge CLK or posedge RSTn) begin
        if (RSTn)          esc_lim <= ESC_LIM;
        else if (sensed)   esc_lim <= ESC_W'(HYST_TICKS);
        else if (pace_evt) esc_lim <= ESC_LIM;
    end
`else
    assign esc_lim = ESC_LIM;
`endif

    always_ff @(posedge CLK or posedge RSTn) begin
        if (RSTn) begin
            state    <= REFRACT;
            esc_cnt  <= '0;
            pace_cnt <= '0;
            LED_PACE <= 1'b0;
        end else begin
            state    <= state_d;
            esc_cnt  <= esc_d;
            pace_cnt <= pace_cnt_d;
            LED_PACE <= pace_d;
        end
    end

    always_comb begin
        state_d    = state;
        esc_d      = esc_cnt;
        pace_cnt_d = pace_cnt;
        pace_d     = LED_PACE;
        case (state)
            REFRACT, ALERT: begin
                if (sensed) begin
                    state_d = REFRACT;
                    esc_d   = '0;
                end else if (pace_evt) begin
                    state_d    = PACE;
                    pace_d     = 1'b1;
                    pace_cnt_d = PUL_LOAD;
                end else if (tick) begin
                    esc_d = esc_cnt + ESC_W'(1);
                    if ((state == REFRACT) && (esc_d >= REF_LIM)) state_d = ALERT;
                end
            end
            PACE: begin
                if (pace_cnt != '0) begin
                    pace_cnt_d = pace_cnt - PUL_W'(1);
                end else begin
                    pace_d  = 1'b0;
                    state_d = REFRACT;
                    esc_d   = '0;
                end
            end
            default: state_d = REFRACT;
        endcase
    end

endmodule

// File: tb/tb_top.sv
// Bench for the pacemaker core: an event-level heart/escape model predicts both LEDs every clock
// for two instances (default, and escape equal to the minimum intrinsic interval).
module tb_top;
    localparam int TICK_DIV = 10;
    localparam int PULSE    = 4;
    localparam int REFRACT  = 8;
    localparam int N_CYC    = 2000;
    localparam int MAXT     = 260;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic heart_a, pace_a, heart_b, pace_b;

    always #5 clk = ~clk;

    top dut_a (.CLK(clk), .RSTn(rst), .LED_HEART(heart_a), .LED_PACE(pace_a));
    top #(.ESCAPE_TICKS(20), .LFSR_SEED(8'h40)) dut_b (
        .CLK(clk), .RSTn(rst), .LED_HEART(heart_b), .LED_PACE(pace_b));

    typedef struct {
        int   cyc;
        logic heart;
        logic pace;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] exp_q[$];
    bit         ev_h[2][MAXT];
    bit         ev_p[2][MAXT];
    int         n_checks = 0;
    int         n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endfunction

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) | fb) & 255;
    endfunction

    // Event list per tick: beats at absolute deadlines, pace when the escape deadline comes first.
    function automatic void build_model(input int inst, input int esc_ticks, input int seed);
        int l, next_beat, base, lim;
        bit is_beat, is_esc;
        l = seed;
        next_beat = 20 + (l % 64);
        base = 0;
        lim = esc_ticks;
        for (int t = 0; t < MAXT; t++) begin
            ev_h[inst][t] = 1'b0;
            ev_p[inst][t] = 1'b0;
        end
        for (int t = 1; t < MAXT; t++) begin
            is_beat = (t == next_beat);
            is_esc  = (t == base + lim);
            if (is_beat) begin
                ev_h[inst][t] = 1'b1;
                l = lfsr_next(l);
                next_beat = t + 20 + (l % 64);
                if ((t > base + REFRACT) || is_esc) begin
                    base = t;
`ifdef PACE_HYST_EN
                    lim = 50;
`else
                    lim = esc_ticks;
`endif
                end
            end else if (is_esc) begin
                ev_p[inst][t] = 1'b1;
                l = lfsr_next(l);
                next_beat = t + 20 + (l % 64);
                base = t;
                lim = esc_ticks;
            end
        end
    endfunction

    // Expected {heart_a, pace_a, heart_b, pace_b} after the c-th rising edge since reset release.
    function automatic logic [3:0] expect_at(input int c);
        int t;
        bit on;
        t  = c / TICK_DIV;
        on = (t >= 1) && (t < MAXT) && ((c % TICK_DIV) < PULSE);
        if (!on) return 4'b0000;
        return {ev_h[0][t], ev_p[0][t], ev_h[1][t], ev_p[1][t]};
    endfunction

    function automatic void add_vec(input int c, input logic h, input logic p);
        vec_t v;
        v.cyc = c;
        v.heart = h;
        v.pace = p;
        tbl.push_back(v);
    endfunction

    task automatic do_reset(input int hold);
        rst = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            check("reset_leds", 32'({heart_a, pace_a, heart_b, pace_b}), 32'h0);
        end
        rst = 1'b0;
    endtask

    task automatic run_segment();
        int ti, hw, pw, last_rise;
        logic prev_any, any;
        logic [3:0] got;
        exp_q = {};
        for (int c = 1; c <= N_CYC; c++) exp_q.push_back(expect_at(c));
        ti = 0; hw = 0; pw = 0; last_rise = -1; prev_any = 1'b0;
        for (int c = 1; c <= N_CYC; c++) begin
            @(negedge clk);
            got = {heart_a, pace_a, heart_b, pace_b};
            check($sformatf("model_cyc%0d", c), 32'(got), 32'(exp_q.pop_front()));
            if (ti < tbl.size() && tbl[ti].cyc == c) begin
                check($sformatf("vec_cyc%0d", c), 32'({heart_a, pace_a}),
                      32'({tbl[ti].heart, tbl[ti].pace}));
                ti++;
            end
            if (c >= 200 && c <= 203)
                check($sformatf("coincide_b_cyc%0d", c), 32'({heart_b, pace_b}), 32'h2);
            if (heart_a) hw++;
            else if (hw > 0) begin
                check("heart_width", 32'(hw), 32'(PULSE));
                hw = 0;
            end
            if (pace_a) pw++;
            else if (pw > 0) begin
                check("pace_width", 32'(pw), 32'(PULSE));
                pw = 0;
            end
            any = heart_a | pace_a;
            if (any && !prev_any) begin
                if (last_rise >= 0)
                    check("event_gap_ok", 32'((c - last_rise) >= 8 * TICK_DIV), 32'h1);
                last_rise = c;
            end
            prev_any = any;
        end
        check("table_consumed", 32'(ti), 32'(tbl.size()));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic prev_p;

        build_model(0, 40, 8'hA5);
        build_model(1, 20, 8'h40);

        add_vec(1,    1'b0, 1'b0);
        add_vec(399,  1'b0, 1'b0);
        add_vec(400,  1'b0, 1'b1);
        add_vec(403,  1'b0, 1'b1);
        add_vec(404,  1'b0, 1'b0);
        add_vec(699,  1'b0, 1'b0);
        add_vec(700,  1'b1, 1'b0);
        add_vec(703,  1'b1, 1'b0);
        add_vec(704,  1'b0, 1'b0);
        add_vec(800,  1'b0, 1'b0);
`ifndef PACE_HYST_EN
        add_vec(1099, 1'b0, 1'b0);
        add_vec(1100, 1'b0, 1'b1);
        add_vec(1500, 1'b0, 1'b1);
        add_vec(1900, 1'b1, 1'b0);
        add_vec(1903, 1'b1, 1'b0);
        add_vec(1904, 1'b0, 1'b0);
`endif

        do_reset($urandom_range(2, 6));
        run_segment();

        // Catch the rising edge of a pace pulse, then assert reset between clock edges.
        found = 1'b0;
        prev_p = pace_a;
        for (int i = 0; i < 1500 && !found; i++) begin
            @(negedge clk);
            if (pace_a && !prev_p) found = 1'b1;
            prev_p = pace_a;
        end
        check("pace_seen_before_reset", 32'(found), 32'h1);
        if (found) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check("pace_high_before_reset", 32'(pace_a), 32'h1);
            #($urandom_range(1, 3));
            rst = 1'b1;
            #1;
            check("async_clear", 32'({heart_a, pace_a, heart_b, pace_b}), 32'h0);
        end

        do_reset($urandom_range(2, 5));
        run_segment();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
